// File: rtl/bsg_mcl_sched_pkg.sv
// Shared packet layout constants and views for the manycore host request scheduler.
// Requests and responses travel as flat 128-bit words; the structs document the field order.
package bsg_mcl_sched_pkg;

   localparam int req_payload_lsb_lp = 32;
   localparam int req_op_lsb_lp      = 72;
   localparam int rsp_load_id_lsb_lp = 16;

   localparam logic [7:0] op_load = 8'd0;

   typedef struct packed {
      logic [15:0] padding;
      logic [31:0] addr;
      logic [7:0]  op;
      logic [7:0]  op_ex;
      logic [31:0] payload;
      logic [7:0]  src_y;
      logic [7:0]  src_x;
      logic [7:0]  y;
      logic [7:0]  x;
   } host_req_pkt_s;

   typedef struct packed {
      logic [39:0] padding;
      logic [7:0]  pkt_type;
      logic [31:0] data;
      logic [31:0] load_id;
      logic [7:0]  y;
      logic [7:0]  x;
   } host_rsp_pkt_s;

endpackage

// File: rtl/bsg_mcl_sched_out_reg.sv
// Single-entry valid/ready register; it refills in the same cycle it drains,
// so a steady stream passes at one packet per cycle.
module bsg_mcl_sched_out_reg
  #(parameter int width_p = 128)
   (input  logic               clk_i
   ,input  logic               reset_i
   ,input  logic               v_i
   ,input  logic [width_p-1:0] data_i
   ,output logic               ready_o
   ,output logic               v_o
   ,output logic [width_p-1:0] data_o
   ,input  logic               rdy_i
   );

   assign ready_o = !v_o || rdy_i;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         v_o    <= 1'b0;
         data_o <= '0;
      end
      else if (ready_o) begin
         v_o <= v_i;
         if (v_i)
            data_o <= data_i;
      end
   end

endmodule

// File: rtl/bsg_mcl_host_req_scheduler.sv
// Round-robin sharing of one manycore endpoint request port among host requesters,
// with load tagging, per-requester outstanding-load limits and response routing.
module bsg_mcl_host_req_scheduler
   import bsg_mcl_sched_pkg::*;
  #(parameter int num_req_p         = 4
   ,parameter int max_out_credits_p = 16
   ,parameter int max_per_req_p     = 8
   ,parameter int tag_lsb_p         = 24
   ,localparam int lg_req_lp        = (num_req_p > 1) ? $clog2(num_req_p) : 1
   ,localparam int cnt_width_lp     = $clog2(max_per_req_p+1)
   ,localparam int credit_width_lp  = $clog2(max_out_credits_p+1)
   )
   (input  logic                                    clk_i
   ,input  logic                                    reset_i
   ,input  logic [num_req_p-1:0]                    req_v_i
   ,input  logic [num_req_p-1:0][127:0]             req_data_i
   ,output logic [num_req_p-1:0]                    req_rdy_o
   ,output logic                                    out_v_o
   ,output logic [127:0]                            out_data_o
   ,input  logic                                    out_rdy_i
   ,input  logic [credit_width_lp-1:0]              out_credits_i
   ,input  logic                                    rsp_v_i
   ,input  logic [127:0]                            rsp_data_i
   ,output logic                                    rsp_rdy_o
   ,output logic [num_req_p-1:0]                    rsp_v_o
   ,output logic [num_req_p-1:0][127:0]             rsp_data_o
   ,input  logic [num_req_p-1:0]                    rsp_rdy_i
   ,output logic [num_req_p-1:0][cnt_width_lp-1:0]  outstanding_o
   ,output logic                                    err_o
   );

   logic [lg_req_lp-1:0] rr_ptr_r, winner, dest;
   logic [num_req_p-1:0] is_load, eligible, inc, dec;
   logic [num_req_p-1:0][cnt_width_lp-1:0] cnt_r;
   logic found, can_load, grant_v, bad_tag, err_r;
   logic [127:0] tagged_data;

   always_comb begin
      for (int i = 0; i < num_req_p; i++) begin
         is_load[i]  = (req_data_i[i][req_op_lsb_lp +: 8] == op_load);
         eligible[i] = req_v_i[i] && (out_credits_i != '0)
                       && (!is_load[i] || (cnt_r[i] < cnt_width_lp'(max_per_req_p)));
      end
   end

   // Search starts at the pointer so the requester after the last winner has priority.
   always_comb begin
      int idx;
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = 0; k < num_req_p; k++) begin
         idx = (int'(rr_ptr_r) + k) % num_req_p;
         if (!found && eligible[idx]) begin
            found  = 1'b1;
            winner = lg_req_lp'(idx);
         end
      end
   end

   assign grant_v = found && can_load && !reset_i;

   always_comb begin
      req_rdy_o = '0;
      if (grant_v)
         req_rdy_o[winner] = 1'b1;
   end

   always_comb begin
      tagged_data = req_data_i[winner];
      if (is_load[winner])
         tagged_data[req_payload_lsb_lp + tag_lsb_p +: lg_req_lp] = winner;
   end

   bsg_mcl_sched_out_reg #(.width_p(128)) out_reg
     (.clk_i   (clk_i)
     ,.reset_i (reset_i)
     ,.v_i     (grant_v)
     ,.data_i  (tagged_data)
     ,.ready_o (can_load)
     ,.v_o     (out_v_o)
     ,.data_o  (out_data_o)
     ,.rdy_i   (out_rdy_i)
     );

   // A tag outside the requester range is swallowed so the endpoint never stalls on it.
   assign dest    = rsp_data_i[rsp_load_id_lsb_lp + tag_lsb_p +: lg_req_lp];
   assign bad_tag = (int'(dest) >= num_req_p);

   always_comb begin
      rsp_v_o   = '0;
      rsp_rdy_o = 1'b1;
      if (!bad_tag) begin
         rsp_v_o[dest] = rsp_v_i;
         rsp_rdy_o     = rsp_rdy_i[dest];
      end
   end

   always_comb begin
      for (int i = 0; i < num_req_p; i++) begin
         rsp_data_o[i] = rsp_data_i;
         inc[i] = grant_v && (winner == lg_req_lp'(i)) && is_load[i];
         dec[i] = rsp_v_i && rsp_rdy_o && !bad_tag && (dest == lg_req_lp'(i));
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rr_ptr_r <= '0;
         err_r    <= 1'b0;
         cnt_r    <= '0;
      end
      else begin
         if (grant_v)
            rr_ptr_r <= (winner == lg_req_lp'(num_req_p-1)) ? '0 : winner + lg_req_lp'(1);
         if (rsp_v_i && bad_tag)
            err_r <= 1'b1;
         for (int i = 0; i < num_req_p; i++) begin
            if (inc[i] && !dec[i])
               cnt_r[i] <= cnt_r[i] + cnt_width_lp'(1);
            else if (dec[i] && !inc[i])
               cnt_r[i] <= cnt_r[i] - cnt_width_lp'(1);
         end
      end
   end

   always @(posedge clk_i) begin
      if (!reset_i)
         for (int i = 0; i < num_req_p; i++)
            assert (!(dec[i] && !inc[i] && (cnt_r[i] == '0)));
   end

   assign outstanding_o = cnt_r;
   assign err_o         = err_r;

endmodule
